// File: rtl/enigma_pkg.sv
// Shared types and constants for the Enigma letter path.
package enigma_pkg;

  localparam int unsigned LETTER_W = 6;
  localparam int unsigned ENTRY_W  = LETTER_W + 1;

  localparam logic [7:0] ASC_A  = 8'h41;
  localparam logic [7:0] ASC_Z  = 8'h5A;
  localparam logic [7:0] ASC_LA = 8'h61;
  localparam logic [7:0] ASC_LZ = 8'h7A;
  localparam logic [7:0] ASC_CR = 8'h0D;
  localparam logic [7:0] ASC_LF = 8'h0A;

  // One FIFO slot: end-of-message flag above the letter index.
  typedef struct packed {
    logic                eom;
    logic [LETTER_W-1:0] letter;
  } letter_entry_t;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MSG  = 1'b1
  } map_state_e;

endpackage

// File: rtl/uart_map_in_if.sv
// RX byte strobe in, letter stream out over valid/ready.
interface uart_map_in_if;
  import enigma_pkg::*;

  logic [7:0]          rx_data;
  logic                rx_valid;
  logic [LETTER_W-1:0] letter_data;
  logic                letter_eom;
  logic                letter_valid;
  logic                letter_ready;

  // Mapper side: consumes RX bytes, produces letters.
  modport master (
    input  rx_data, rx_valid, letter_ready,
    output letter_data, letter_eom, letter_valid
  );

  // Environment side: UART RX plus the Enigma core consumer.
  modport slave (
    output rx_data, rx_valid, letter_ready,
    input  letter_data, letter_eom, letter_valid
  );
endinterface

// File: rtl/uart_in_fifo.sv
// Generic first-word-fall-through FIFO with an explicit level counter.
module uart_in_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned W     = 7
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         empty,
  output logic         full,
  output logic [AW:0]  level
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          do_push;
  logic          do_pop;

  assign empty = (level_q == '0);
  assign full  = (level_q == (AW+1)'(DEPTH));

  // Pop on empty is ignored; a push into a full FIFO only lands if a pop frees a slot.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // Storage, pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + AW'(1);
      if (do_push && !do_pop)      level_q <= level_q + (AW+1)'(1);
      else if (do_pop && !do_push) level_q <= level_q - (AW+1)'(1);
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign level = level_q;

endmodule

// File: rtl/uart_map_in.sv
// Maps received ASCII to letter indices / EOM markers and buffers them for the core.
module uart_map_in
  import enigma_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 2,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  uart_map_in_if.master    bus,
  output logic [AW:0]      fifo_level,
  output logic             overflow,
  output logic [CNT_W-1:0] drop_count,
  input  logic             clear_status
);

  map_state_e     state_q, state_d;
  logic           overflow_q, overflow_d;
  logic [CNT_W-1:0] drop_q, drop_d;

  logic           is_letter_c, is_term_c, is_reject_c;
  logic [LETTER_W-1:0] index_c;
  logic           want_push_c, push_c, lost_c, pop_c;
  letter_entry_t  entry_c, head_c;
  logic [ENTRY_W-1:0] fifo_dout;
  logic           fifo_empty, fifo_full;

  // Byte classification: case-folded letter index, line terminator, or reject.
  always_comb begin
    is_letter_c = 1'b0;
    is_term_c   = 1'b0;
    index_c     = '0;
    if (bus.rx_data >= ASC_A && bus.rx_data <= ASC_Z) begin
      is_letter_c = 1'b1;
      index_c     = LETTER_W'(bus.rx_data - ASC_A);
    end else if (bus.rx_data >= ASC_LA && bus.rx_data <= ASC_LZ) begin
      is_letter_c = 1'b1;
      index_c     = LETTER_W'(bus.rx_data - ASC_LA);
    end else if (bus.rx_data == ASC_CR || bus.rx_data == ASC_LF) begin
      is_term_c   = 1'b1;
    end
    is_reject_c = bus.rx_valid & ~is_letter_c & ~is_term_c;
  end

  assign pop_c = ~fifo_empty & bus.letter_ready;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next state and push decision; terminators only count after a letter.
  always_comb begin
    state_d       = state_q;
    want_push_c   = 1'b0;
    entry_c       = '0;
    if (bus.rx_valid) begin
      if (is_letter_c) begin
        want_push_c    = 1'b1;
        entry_c.letter = index_c;
      end else if (is_term_c && state_q == S_MSG) begin
        want_push_c = 1'b1;
        entry_c.eom = 1'b1;
      end
    end
    push_c = want_push_c & (~fifo_full | pop_c);
    lost_c = want_push_c & ~push_c;
    if (push_c) state_d = entry_c.eom ? S_IDLE : S_MSG;
  end

  // Status next-state; clear overrides any same-cycle event.
  always_comb begin
    overflow_d = overflow_q;
    drop_d     = drop_q;
    if (clear_status) begin
      overflow_d = 1'b0;
      drop_d     = '0;
    end else begin
      if (lost_c) overflow_d = 1'b1;
      if (is_reject_c && drop_q != '1) drop_d = drop_q + CNT_W'(1);
    end
  end

  // Status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_q <= 1'b0;
      drop_q     <= '0;
    end else begin
      overflow_q <= overflow_d;
      drop_q     <= drop_d;
    end
  end

  uart_in_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW),
    .W     (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push_c),
    .pop   (pop_c),
    .din   (entry_c),
    .dout  (fifo_dout),
    .empty (fifo_empty),
    .full  (fifo_full),
    .level (fifo_level)
  );

  assign head_c           = letter_entry_t'(fifo_dout);
  assign bus.letter_data  = head_c.letter;
  assign bus.letter_eom   = head_c.eom;
  assign bus.letter_valid = ~fifo_empty;
  assign overflow         = overflow_q;
  assign drop_count       = drop_q;

endmodule

// File: tb/tb_uart_map_in.sv
// Scoreboard bench for uart_map_in: randomized bytes against a queue-based model.
module tb_uart_map_in;

  localparam int DEPTH = 4;

  logic       clk;
  logic       rst_n;
  logic       clear_status;
  logic [2:0] fifo_level;
  logic       overflow;
  logic [7:0] drop_count;

  uart_map_in_if bus();

  uart_map_in #(.DEPTH(4), .AW(2), .CNT_W(8)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .drop_count   (drop_count),
    .clear_status (clear_status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d @%0t", name, act, expv, $time);
    end
  endtask

  // Reference model: the FIFO is just the queue of entries the core should see.
  logic [6:0] exp_q[$];
  int         m_level = 0;
  bit         m_msg   = 0;
  bit         m_ovf   = 0;
  int         m_drop  = 0;

  always @(posedge clk or negedge rst_n) begin
    automatic bit         pop, want, lost, rej;
    automatic logic [6:0] e;
    automatic logic [7:0] b;
    if (!rst_n) begin
      exp_q.delete();
      m_level = 0; m_msg = 0; m_ovf = 0; m_drop = 0;
    end else begin
      pop = bus.letter_ready && (m_level > 0);
      want = 0; lost = 0; rej = 0; e = '0;
      b = bus.rx_data;
      if (bus.rx_valid) begin
        if (b >= "A" && b <= "Z")      begin want = 1; e = {1'b0, 6'(b - "A")}; end
        else if (b >= "a" && b <= "z") begin want = 1; e = {1'b0, 6'(b - "a")}; end
        else if (b == 8'd13 || b == 8'd10) begin
          if (m_msg) begin want = 1; e = 7'h40; end
        end else rej = 1;
      end
      if (want) begin
        if (m_level < DEPTH || pop) begin
          exp_q.push_back(e);
          m_level++;
          m_msg = !e[6];
        end else lost = 1;
      end
      if (pop) m_level--;
      if (clear_status) begin m_ovf = 0; m_drop = 0; end
      else begin
        if (lost) m_ovf = 1;
        if (rej && m_drop < 255) m_drop++;
      end
    end
  end

  // Monitor: mid-cycle compare of head entry and status against the model.
  always @(negedge clk) begin
    automatic logic [6:0] e;
    if (rst_n === 1'b1) begin
      chk("letter_valid", bus.letter_valid, (m_level > 0));
      chk("fifo_level", fifo_level, m_level);
      chk("overflow", overflow, m_ovf);
      chk("drop_count", drop_count, m_drop);
      if (m_level > 0 && bus.letter_ready) begin
        e = exp_q.pop_front();
        chk("letter_data", bus.letter_data, e[5:0]);
        chk("letter_eom", bus.letter_eom, e[6]);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    step(1);
    bus.rx_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  task automatic drain();
    int n;
    bus.letter_ready = 1'b1;
    n = 0;
    while (m_level > 0 && n < 50) begin step(1); n++; end
    chk("drain_timeout", (m_level > 0), 0);
  endtask

  initial begin
    automatic int r;
    automatic logic [7:0] pick;
    rst_n = 1'b1;
    clear_status = 1'b0;
    bus.rx_data = 8'h00;
    bus.rx_valid = 1'b0;
    bus.letter_ready = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid", bus.letter_valid, 0);
    chk("rst_data", bus.letter_data, 0);
    chk("rst_eom", bus.letter_eom, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_drop", drop_count, 0);
    #19 rst_n = 1'b1;
    step(1);

    // 1: "Hi\r\n" -> 7, 8, one EOM
    bus.letter_ready = 1'b1;
    send_str("Hi\r\n");
    drain();
    chk("t1_drop", drop_count, 0);

    // 2: "a?Z" -> 0, 25, one reject
    send_str("a?Z");
    drain();
    chk("t2_drop", drop_count, 1);
    chk("t2_ovf", overflow, 0);

    // 3: five letters into a stalled FIFO
    bus.letter_ready = 1'b0;
    send_str("ABCDE");
    chk("t3_level", fifo_level, 4);
    chk("t3_ovf", overflow, 1);
    drain();

    // 4: full FIFO, push coincides with pop
    clear_status = 1'b1; step(1); clear_status = 1'b0;
    bus.letter_ready = 1'b0;
    send_str("FGHI");
    bus.letter_ready = 1'b1;
    send("J");
    bus.letter_ready = 1'b0;
    chk("t4_level", fifo_level, 4);
    chk("t4_ovf", overflow, 0);
    drain();

    // 5: saturate the reject counter, then clear
    send_str("\n");
    for (int i = 0; i < 300; i++) send("#");
    chk("t5_sat", drop_count, 255);
    clear_status = 1'b1; step(1); clear_status = 1'b0;
    chk("t5_clr", drop_count, 0);
    chk("t5_ovf", overflow, 0);

    // 6: reset mid-stream
    bus.letter_ready = 1'b0;
    send_str("XYZ");
    rst_n = 1'b0;
    #1;
    chk("t6_valid", bus.letter_valid, 0);
    chk("t6_level", fifo_level, 0);
    #3 rst_n = 1'b1;
    step(1);
    bus.letter_ready = 1'b1;
    send_str("\n");
    step(2);
    chk("t6_no_eom", bus.letter_valid, 0);
    send_str("q\r");
    drain();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      r = int'($urandom_range(0, 9));
      case (r)
        0, 1, 2: pick = 8'("A" + $urandom_range(0, 25));
        3, 4:    pick = 8'("a" + $urandom_range(0, 25));
        5:       pick = 8'd13;
        6:       pick = 8'd10;
        default: pick = 8'($urandom_range(0, 255));
      endcase
      bus.rx_data      = pick;
      bus.rx_valid     = ($urandom_range(0, 2) != 0);
      bus.letter_ready = ($urandom_range(0, 2) == 0);
      clear_status     = ($urandom_range(0, 40) == 0);
      step(1);
    end
    bus.rx_valid = 1'b0;
    clear_status = 1'b0;
    drain();
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_map_in.md
Name: uart_map_in

Overview:
Inbound counterpart of the outbound letter mapper. Accepts ASCII bytes strobed from the UART receiver, case-folds A-Z/a-z to a letter index 0..25, turns line terminators into end-of-message markers and discards everything else. Results are buffered in a small first-word-fall-through (FWFT) FIFO. The Enigma core drains the FIFO over a valid/ready handshake. Overflow and discarded-character statistics are exposed for the status display.

Parameters:
DEPTH, 4, FIFO entries; power of 2, >= 2
AW, 2, log2(DEPTH)
CNT_W, 8, width of the drop counter

Ports:
clk  in  1  system clock; the only clock
rst_n  in  1  asynchronous, active-low reset
rx_data  in  8  received ASCII byte; valid only while rx_valid=1
rx_valid  in  1  single-cycle strobe from the UART RX
letter_data  out  6  letter index 0..25; 6'd0 on EOM entries
letter_eom  out  1  1 = head entry is an end-of-message marker
letter_valid  out  1  FIFO non-empty
letter_ready  in  1  consumer accepts the head entry
fifo_level  out  AW+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a push was lost because the FIFO was full
drop_count  out  CNT_W  saturating count of rejected characters
clear_status  in  1  synchronous clear of overflow and drop_count

Behaviour:
- Reset (rst_n=0, asynchronous): FIFO empty; letter_valid=0, letter_data=0, letter_eom=0, fifo_level=0, overflow=0, drop_count=0; FSM in S_IDLE.
- Classification (combinational, on rx_data when rx_valid=1):
  - 0x41..0x5A -> index = byte-0x41.
  - 0x61..0x7A -> index = byte-0x61.
  - 0x0D or 0x0A -> terminator.
  - Any other byte -> reject.
- FSM, two states:
  - S_IDLE: no letters since the last EOM.
  - S_MSG: letters pending.
  - Letter, pushed successfully -> S_MSG.
  - Terminator in S_MSG, EOM pushed successfully -> S_IDLE.
  - Terminator in S_IDLE -> ignored. Not counted, not pushed. This collapses CR LF and blank lines into one EOM.
  - Reject -> state unchanged; drop_count+1, saturating at all-ones.
- Push: occurs at the same edge as rx_valid. FIFO entry = {eom, letter[5:0]}.
- Latency: with the FIFO empty, letter_valid rises one cycle after the rx_valid edge, and letter_data is valid in that cycle (FWFT).
- Pop: occurs when letter_valid & letter_ready at a rising edge. letter_ready while empty has no effect.
- Full FIFO:
  - Push with pop in the same cycle: both proceed; level unchanged; no overflow.
  - Push without pop: entry discarded; overflow<=1; FSM unchanged. A lost EOM leaves the FSM in S_MSG, so the next terminator retries.
  - A lost letter does not increment drop_count.
- Empty FIFO with push and letter_ready both high: push only. The entry appears the next cycle; no bypass.
- Pointers wrap modulo DEPTH. fifo_level is kept as an explicit counter, +1 on push only, -1 on pop only.
- clear_status:
  - overflow<=0 and drop_count<=0.
  - If an overflow or reject happens in the same cycle, clear wins and the event is not recorded.
  - The FIFO and FSM are unaffected.
- Reset mid-stream: FIFO contents are discarded immediately, and the outputs take their reset values asynchronously.

Decomposition:
- Shared package enigma_pkg:
  - LETTER_W=6.
  - ASCII constants ASC_A, ASC_Z, ASC_LA, ASC_LZ, ASC_CR, ASC_LF.
  - Packed typedef letter_entry_t {eom, letter}.
- One sub-module, uart_in_fifo: generic FWFT FIFO.
  - Parameters DEPTH/AW/entry width.
  - Ports: push, pop, din, dout, empty, full, level.
- Classification and the FSM stay in uart_map_in.

Test Plan:
1. Send "Hi\r\n" with letter_ready=1 -> entries 7, 8, then one EOM (eom=1, data=0). No second EOM; drop_count=0.
2. Send "a?Z" -> entries 0, 25; drop_count=1; overflow=0.
3. Hold letter_ready=0 and send 5 letters with DEPTH=4 -> fifo_level=4, overflow=1. Then drain -> exactly the first 4 letters, in order.
4. FIFO full; next rx_valid coincides with a pop -> level stays 4; overflow stays 0; new letter appears last.
5. Send 300 '#' bytes, then pulse clear_status -> drop_count saturates at 255, then reads 0; overflow=0.
6. Fill with 3 entries; assert rst_n=0 mid-stream -> letter_valid=0 and fifo_level=0 immediately. After release, "\n" yields no EOM (FSM back in S_IDLE).
